// File: rtl/leitor_entrada.sv
// leitor_entrada
//   Serves the processor's IN instruction. It sits directly after the
//   switch/button input block. While the CPU asks for input it is held in
//   stall. A debounced press edge captures the switch word. The word is
//   extended to CPU width and delivered with a one-cycle ready pulse. The
//   button must be released before the next capture can happen. A blinking
//   LED shows that the block is waiting for a press. A counter tracks how
//   many inputs have been accepted.
//
// Ports
//   i_clock           system clock, all state on the rising edge
//   i_reset           asynchronous, active-high reset
//   i_dadoEntrada     switch word from the input block (quasi-static)
//   i_botaoEstavel    debounced button, 1 = pressed
//   i_pedeEntrada     CPU executing IN, held high until o_dadoPronto is seen
//   o_dadoCpu         captured, extended word; holds its last value
//   o_dadoPronto      one-cycle pulse: o_dadoCpu is valid for the IN
//   o_stallCpu        combinational: i_pedeEntrada & ~o_dadoPronto
//   o_ledEspera       blinks while waiting for a press, 0 otherwise
//   o_contaEntradas   number of accepted inputs, wraps 255 -> 0
//
// States
//   OCIOSO       | idle, no request pending
//   ESPERA_PRESS | request pending, waiting for a press edge, LED blinking
//   ENTREGA      | word delivered, o_dadoPronto high for this cycle only
//   ESPERA_SOLTA | waiting for the button to be released
module leitor_entrada #(
  parameter int DATA_W    = 15,
  parameter int CPU_W     = 32,   // must be >= DATA_W
  parameter int SIGN_EXT  = 1,
  parameter int PISCA_DIV = 6250000
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_dadoEntrada,
  input  logic              i_botaoEstavel,
  input  logic              i_pedeEntrada,
  output logic [CPU_W-1:0]  o_dadoCpu,
  output logic              o_dadoPronto,
  output logic              o_stallCpu,
  output logic              o_ledEspera,
  output logic [7:0]        o_contaEntradas
);

  typedef enum logic [1:0] {
    OCIOSO       = 2'd0,
    ESPERA_PRESS = 2'd1,
    ENTREGA      = 2'd2,
    ESPERA_SOLTA = 2'd3
  } estado_t;

  // The +1 keeps the width at 1 or more when PISCA_DIV is 1.
  localparam int PW = $clog2(PISCA_DIV + 1);
  localparam logic [PW-1:0] PISCA_MAX = PW'(PISCA_DIV - 1);

  estado_t           r_estado;
  estado_t           w_prox;
  logic              r_botao_ant;
  logic [CPU_W-1:0]  r_dado_cpu;
  logic [7:0]        r_conta;
  logic              r_led;
  logic [PW-1:0]     r_pisca_cnt;
  logic              w_borda;
  logic              w_captura;
  logic              w_pisca_ativo;
  logic [CPU_W-1:0]  w_ext;

  assign w_borda = i_botaoEstavel & ~r_botao_ant;

  generate
    if (CPU_W > DATA_W) begin : g_ext
      logic w_bit_ext;
      assign w_bit_ext = (SIGN_EXT != 0) ? i_dadoEntrada[DATA_W-1] : 1'b0;
      assign w_ext     = {{(CPU_W - DATA_W){w_bit_ext}}, i_dadoEntrada};
    end else begin : g_sem_ext
      assign w_ext = i_dadoEntrada;
    end
  endgenerate

  always_comb begin
    w_prox    = r_estado;
    w_captura = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (i_pedeEntrada) w_prox = ESPERA_PRESS;
      end
      ESPERA_PRESS: begin
        // An abort takes priority over a press edge in the same cycle.
        if (!i_pedeEntrada) begin
          w_prox = OCIOSO;
        end else if (w_borda) begin
          w_prox    = ENTREGA;
          w_captura = 1'b1;
        end
      end
      ENTREGA: begin
        w_prox = ESPERA_SOLTA;
      end
      ESPERA_SOLTA: begin
        if (!i_botaoEstavel) w_prox = OCIOSO;
      end
      default: w_prox = OCIOSO;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_estado    <= OCIOSO;
      r_botao_ant <= 1'b0;
      r_dado_cpu  <= '0;
      r_conta     <= 8'd0;
    end else begin
      r_estado    <= w_prox;
      r_botao_ant <= i_botaoEstavel;
      if (w_captura) begin
        r_dado_cpu <= w_ext;
        r_conta    <= r_conta + 8'd1;
      end
    end
  end

  // The blink counter runs only while the FSM stays in ESPERA_PRESS.
  // Clearing on the leaving edge makes the LED read 0 in the first cycle
  // outside that state.
  assign w_pisca_ativo = (r_estado == ESPERA_PRESS) && (w_prox == ESPERA_PRESS);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pisca_cnt <= '0;
      r_led       <= 1'b0;
    end else if (!w_pisca_ativo) begin
      r_pisca_cnt <= '0;
      r_led       <= 1'b0;
    end else if (r_pisca_cnt == PISCA_MAX) begin
      r_pisca_cnt <= '0;
      r_led       <= ~r_led;
    end else begin
      r_pisca_cnt <= r_pisca_cnt + 1'b1;
    end
  end

  // Decoded from state so that a reset clears the pulse immediately.
  assign o_dadoPronto    = (r_estado == ENTREGA);
  assign o_stallCpu      = i_pedeEntrada & ~o_dadoPronto;
  assign o_dadoCpu       = r_dado_cpu;
  assign o_ledEspera     = r_led;
  assign o_contaEntradas = r_conta;

endmodule

// File: tb/tb_leitor_entrada.sv
// tb_leitor_entrada
//   Two instances share every input: dut (sign extension) and dut_z (zero
//   extension), both using a short blink period. Expected words are pushed
//   into a queue when an IN is issued. A negedge monitor pops an entry and
//   compares it each time o_dadoPronto is high.
module tb_leitor_entrada;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] dado = '0;
  logic        botao = 1'b0;
  logic        pede = 1'b0;

  logic [31:0] cpu_s, cpu_z;
  logic        pronto_s, pronto_z, stall_s, stall_z, led_s, led_z;
  logic [7:0]  conta_s, conta_z;

  int n_chk = 0;
  int n_pass = 0;
  int n_pulse = 0;
  int n_push = 0;
  logic [31:0] q_s[$];
  logic [31:0] q_z[$];

  always #5 clk = ~clk;

  leitor_entrada #(.DATA_W(15), .CPU_W(32), .SIGN_EXT(1), .PISCA_DIV(4)) dut (
    .i_clock(clk), .i_reset(rst), .i_dadoEntrada(dado),
    .i_botaoEstavel(botao), .i_pedeEntrada(pede),
    .o_dadoCpu(cpu_s), .o_dadoPronto(pronto_s), .o_stallCpu(stall_s),
    .o_ledEspera(led_s), .o_contaEntradas(conta_s));

  leitor_entrada #(.DATA_W(15), .CPU_W(32), .SIGN_EXT(0), .PISCA_DIV(4)) dut_z (
    .i_clock(clk), .i_reset(rst), .i_dadoEntrada(dado),
    .i_botaoEstavel(botao), .i_pedeEntrada(pede),
    .o_dadoCpu(cpu_z), .o_dadoPronto(pronto_z), .o_stallCpu(stall_z),
    .o_ledEspera(led_z), .o_contaEntradas(conta_z));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (pronto_s) begin
      n_pulse++;
      if (q_s.size() == 0) chk("unexpected_pulse_s", 32'd1, 32'd0);
      else chk("dadoCpu_sign", cpu_s, q_s.pop_front());
      chk("stall_on_pronto", {31'd0, stall_s}, 32'd0);
    end
    if (pronto_z) begin
      if (q_z.size() == 0) chk("unexpected_pulse_z", 32'd1, 32'd0);
      else chk("dadoCpu_zero", cpu_z, q_z.pop_front());
    end
  end

  // Full IN transaction starting from OCIOSO with the button released.
  task automatic do_in(input logic [14:0] d, input logic [31:0] e_s, input logic [31:0] e_z);
    int k;
    dado = d;
    q_s.push_back(e_s);
    q_z.push_back(e_z);
    n_push++;
    pede = 1'b1;
    cyc(2);
    botao = 1'b1;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pronto_s) break;
    end
    if (k == 10) chk("timeout_pronto", 32'd0, 32'd1);
    else chk("latency", k, 32'd1);
    @(posedge clk); #1;
    pede = 1'b0;
    botao = 1'b0;
    cyc(2);
  endtask

  initial begin
    int k;
    logic [31:0] c0;
    // Reset state
    #2;
    chk("rst_dadoCpu", cpu_s, 32'd0);
    chk("rst_pronto", {31'd0, pronto_s}, 32'd0);
    chk("rst_led", {31'd0, led_s}, 32'd0);
    chk("rst_conta", {24'd0, conta_s}, 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // 1: basic capture with latency and stall
    pede = 1'b1;
    dado = 15'h0005;
    q_s.push_back(32'h00000005);
    q_z.push_back(32'h00000005);
    n_push++;
    @(negedge clk);
    chk("stall_first_cycle", {31'd0, stall_s}, 32'd1);
    cyc(2);
    botao = 1'b1;
    @(negedge clk);
    chk("pronto_before_edge", {31'd0, pronto_s}, 32'd0);
    chk("stall_before_edge", {31'd0, stall_s}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pronto_after_edge", {31'd0, pronto_s}, 32'd1);
    chk("stall_drops", {31'd0, stall_s}, 32'd0);
    chk("conta_1", {24'd0, conta_s}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pronto_one_cycle", {31'd0, pronto_s}, 32'd0);
    pede = 1'b0;
    botao = 1'b0;
    cyc(2);

    // 2: extension
    do_in(15'h4001, 32'hFFFFC001, 32'h00004001);
    do_in(15'h3FFF, 32'h00003FFF, 32'h00003FFF);
    do_in(15'h7FFF, 32'hFFFFFFFF, 32'h00007FFF);
    chk("conta_4", {24'd0, conta_s}, 32'd4);

    // 3: button held before request is not a press
    botao = 1'b1;
    cyc(1);
    pede = 1'b1;
    dado = 15'h0777;
    cyc(6);
    chk("held_no_capture_conta", {24'd0, conta_s}, 32'd4);
    chk("held_dado_unchanged", cpu_s, 32'hFFFFFFFF);
    chk("held_still_stall", {31'd0, stall_s}, 32'd1);
    botao = 1'b0;
    cyc(1);
    dado = 15'h0123;
    q_s.push_back(32'h00000123);
    q_z.push_back(32'h00000123);
    n_push++;
    botao = 1'b1;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pronto_s) break;
    end
    chk("held_then_press", k, 32'd1);
    @(posedge clk); #1;
    pede = 1'b0;
    botao = 1'b0;
    cyc(2);
    chk("conta_5", {24'd0, conta_s}, 32'd5);

    // 4: button held across two back-to-back requests
    pede = 1'b1;
    dado = 15'h0AAA;
    q_s.push_back(32'h00000AAA);
    q_z.push_back(32'h00000AAA);
    n_push++;
    cyc(2);
    botao = 1'b1;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pronto_s) break;
    end
    chk("b2b_first", k, 32'd1);
    @(posedge clk); #1;
    pede = 1'b0;
    @(posedge clk); #1;
    pede = 1'b1;
    dado = 15'h0555;
    q_s.push_back(32'h00000555);
    q_z.push_back(32'h00000555);
    n_push++;
    cyc(5);
    chk("b2b_stalled", {31'd0, stall_s}, 32'd1);
    chk("b2b_conta_mid", {24'd0, conta_s}, 32'd6);
    botao = 1'b0;
    cyc(2);
    botao = 1'b1;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pronto_s) break;
    end
    chk("b2b_second", k, 32'd1);
    @(posedge clk); #1;
    pede = 1'b0;
    botao = 1'b0;
    cyc(2);
    chk("b2b_conta", {24'd0, conta_s}, 32'd7);

    // 5: LED blink, then abort with simultaneous press
    pede = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      chk("led_blink", {31'd0, led_s}, {31'd0, ((j / 4) % 2) == 1});
      if (j < 12) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    pede = 1'b0;
    botao = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("led_after_leave", {31'd0, led_s}, 32'd0);
    chk("abort_no_count", {24'd0, conta_s}, 32'd7);
    chk("abort_dado_kept", cpu_s, 32'h00000555);
    botao = 1'b0;
    cyc(2);

    // 6: reset during ENTREGA
    pede = 1'b1;
    dado = 15'h1234;
    cyc(2);
    botao = 1'b1;
    @(posedge clk); #1;
    chk("entrega_reached", {31'd0, pronto_s}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_pronto_async", {31'd0, pronto_s}, 32'd0);
    chk("rst_dado_async", cpu_s, 32'd0);
    chk("rst_conta_async", {24'd0, conta_s}, 32'd0);
    pede = 1'b0;
    botao = 1'b0;
    #1;
    rst = 1'b0;
    cyc(2);

    // Counter wrap
    for (int i = 0; i < 255; i++) begin
      c0 = 32'(i);
      do_in(15'(i), c0, c0);
    end
    chk("conta_255", {24'd0, conta_s}, 32'd255);
    do_in(15'h0042, 32'h00000042, 32'h00000042);
    chk("conta_wrap", {24'd0, conta_s}, 32'd0);

    cyc(2);
    chk("pulse_count", n_pulse, n_push);
    chk("queue_empty", q_s.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
